// File: rtl/serial_rx_deframer.sv
// serial_rx_deframer: 8N1 LSB-first asynchronous serial receiver.
// The rx line is brought into the clk domain through two flops. Each byte
// is timed with CLK_PER_BIT clocks per bit and sampled at mid-bit.
//
// Optional feature macro: SERIAL_RX_FRAME_ERR_EN
//   defined   : a low stop bit pulses frame_err, drops the byte, and parks
//               the FSM in BREAK until the line returns high.
//   undefined : the stop bit is not checked and frame_err is tied 0.
//
// Output handshake: there is no back-pressure. new_data is a one-cycle
// valid strobe with no ready. data is valid in that cycle and holds its
// value until the next strobe. frame_err is a one-cycle strobe and is never
// high together with new_data.
module serial_rx_deframer #(
    parameter int CLK_PER_BIT = 50,
    parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       busy,
    output logic       frame_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
`ifdef SERIAL_RX_FRAME_ERR_EN
        , BREAK = 3'd4
`endif
    } state_t;

    localparam logic [CTR_SIZE-1:0] BIT_LAST  = CTR_SIZE'(CLK_PER_BIT - 1);
    localparam logic [CTR_SIZE-1:0] HALF_LAST = CTR_SIZE'(CLK_PER_BIT / 2 - 1);

    state_t              state, state_nxt;
    logic                rx_meta, rx_s;
    logic [CTR_SIZE-1:0] ctr, ctr_nxt;
    logic [2:0]          bit_ctr, bit_ctr_nxt;
    logic [7:0]          sreg, sreg_nxt;
    logic [7:0]          data_nxt;
    logic                new_data_nxt;
`ifdef SERIAL_RX_FRAME_ERR_EN
    logic                frame_err_nxt;
    logic                frame_err_q;
`endif

    assign state_dbg = state;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Next-state logic: bit timing, mid-bit sampling and stop-bit handling.
    always_comb begin
        state_nxt    = state;
        ctr_nxt      = ctr;
        bit_ctr_nxt  = bit_ctr;
        sreg_nxt     = sreg;
        data_nxt     = data;
        new_data_nxt = 1'b0;
`ifdef SERIAL_RX_FRAME_ERR_EN
        frame_err_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                ctr_nxt     = '0;
                bit_ctr_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                ctr_nxt = ctr + 1'b1;
                if (ctr == HALF_LAST) begin
                    // A line that is high again at mid start bit was a glitch.
                    ctr_nxt     = '0;
                    bit_ctr_nxt = '0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                ctr_nxt = ctr + 1'b1;
                if (ctr == BIT_LAST) begin
                    ctr_nxt           = '0;
                    sreg_nxt[bit_ctr] = rx_s;
                    bit_ctr_nxt       = bit_ctr + 3'd1;
                    if (bit_ctr == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                ctr_nxt = ctr + 1'b1;
                if (ctr == BIT_LAST) begin
                    ctr_nxt = '0;
`ifdef SERIAL_RX_FRAME_ERR_EN
                    if (rx_s) begin
                        data_nxt     = sreg;
                        new_data_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        // Hold off in BREAK so a stuck-low line is not read
                        // as a stream of start bits.
                        frame_err_nxt = 1'b1;
                        state_nxt     = BREAK;
                    end
`else
                    data_nxt     = sreg;
                    new_data_nxt = 1'b1;
                    state_nxt    = IDLE;
`endif
                end
            end
`ifdef SERIAL_RX_FRAME_ERR_EN
            BREAK: begin
                ctr_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
                ctr_nxt   = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ctr      <= '0;
            bit_ctr  <= '0;
            sreg     <= 8'h00;
            data     <= 8'h00;
            new_data <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ctr      <= ctr_nxt;
            bit_ctr  <= bit_ctr_nxt;
            sreg     <= sreg_nxt;
            data     <= data_nxt;
            new_data <= new_data_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

`ifdef SERIAL_RX_FRAME_ERR_EN
    // Registered frame error strobe.
    always_ff @(posedge clk) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= frame_err_nxt;
    end
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Testbench for serial_rx_deframer at CLK_PER_BIT = 16.
// The serial line is driven frame by frame from a byte-level model; a
// monitor records every strobe and the scenario tasks compare the recorded
// bytes, strobe times and busy duration against values derived from the
// frame timing (start detect, mid-bit sampling, stop sample).
module tb_serial_rx_deframer;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  // rx driven low just after edge n -> rx_s low after n+2 (E) -> START after
  // E+1 -> stop sample at E+1+H+9*CPB; strobe visible right after that edge.
  localparam int LAT      = 3 + H + 9 * CPB;
  localparam int BUSY_LEN = H + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       new_data;
  logic       busy;
  logic       frame_err;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         fe_cnt   = 0;
  int         both_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] last_data = 8'h00;

  serial_rx_deframer #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .new_data  (new_data),
    .busy      (busy),
    .frame_err (frame_err),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record strobes away from the active edge.
  always @(negedge clk) begin
    if (new_data) begin
      got_q.push_back(data);
      got_t.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (new_data && frame_err) both_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    fe_cnt   = 0;
    both_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data); end
    tests++; if (new_data !== 1'b0) begin fails++; $display("FAIL reset_new_data: got %b want 0", new_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst = 1'b0;
    idle(5);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int t0;
    clear_mon();
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    last_data = 8'hA5;
    idle(10);
    tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    tests++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    tests++; if (((got_t.size() > 0) ? got_t[0] - t0 : -1) !== LAT) begin fails++; $display("FAIL single_latency: got %0d want %0d", (got_t.size() > 0) ? got_t[0] - t0 : -1, LAT); end
    tests++; if (busy_cnt !== BUSY_LEN) begin fails++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, BUSY_LEN); end
    tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt); end
    tests++; if (data !== 8'hA5) begin fails++; $display("FAIL single_data_hold: got %h want a5", data); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    last_data = 8'hFF;
    idle(20);
    tests++; if (got_q.size() !== 2) begin fails++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    tests++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'h00) begin fails++; $display("FAIL b2b_first: got %h want 00", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    tests++; if (((got_q.size() > 1) ? got_q[1] : 8'hxx) !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h want ff", (got_q.size() > 1) ? got_q[1] : 8'hxx); end
    tests++; if (((got_t.size() > 1) ? got_t[1] - got_t[0] : -1) !== 10 * CPB) begin fails++; $display("FAIL b2b_spacing: got %0d want %0d", (got_t.size() > 1) ? got_t[1] - got_t[0] : -1, 10 * CPB); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(60);
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL glitch_strobe: got %0d want 0", got_q.size()); end
    tests++; if (busy_cnt !== H) begin fails++; $display("FAIL glitch_busy_len: got %0d want %0d", busy_cnt, H); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_bad_stop();
    clear_mon();
`ifdef SERIAL_RX_FRAME_ERR_EN
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", fe_cnt); end
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL ferr_no_strobe: got %0d want 0", got_q.size()); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
    tests++; if (data !== last_data) begin fails++; $display("FAIL ferr_data_kept: got %h want %h", data, last_data); end
    idle(10);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_break_exit: got %b want 0", busy); end
    send_frame(8'h81, 1'b1);
    last_data = 8'h81;
    idle(10);
    tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL ferr_next_count: got %0d want 1", got_q.size()); end
    tests++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'h81) begin fails++; $display("FAIL ferr_next_data: got %h want 81", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL ferr_once: got %0d want 1", fe_cnt); end
`else
    send_frame(8'h3C, 1'b0);
    last_data = 8'h3C;
    idle(40);
    tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL nochk_count: got %0d want 1", got_q.size()); end
    tests++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'h3C) begin fails++; $display("FAIL nochk_data: got %h want 3c", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL nochk_frame_err: got %0d want 0", fe_cnt); end
`endif
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    clear_mon();
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    last_data = 8'h00;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h want 00", data); end
    idle(200);
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL midrst_no_strobe: got %0d want 0", got_q.size()); end
    send_frame(8'h96, 1'b1);
    last_data = 8'h96;
    idle(10);
    tests++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'h96) begin fails++; $display("FAIL midrst_next: got %h want 96", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    clear_mon();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      idle($urandom_range(0, 12));
    end
    idle(20);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (((i < got_q.size()) ? got_q[i] : 8'hxx) !== exp_q[i]) begin
        fails++;
        $display("FAIL rand_byte%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL rand_frame_err: got %0d want 0", fe_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_bad_stop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
